// File: rtl/adder_4bit_pkg.sv
// Shared width constant and result types for the registered 4-bit ripple-carry adder.
// Optional signed-overflow output is enabled by defining ADDER_4BIT_OVF_EN.
package adder_4bit_pkg;

   localparam int WIDTH = 4;

   typedef logic [WIDTH-1:0] nibble_t;

   typedef struct packed {
      nibble_t sum;
      logic    cout;
   } add_res_t;

endpackage : adder_4bit_pkg

// File: rtl/adder_4bit_seq_if.sv
// Operand/result bundle for adder_4bit_seq; V exists only when ADDER_4BIT_OVF_EN is defined.
// No handshake: the master drives operands every cycle and the slave returns registered results.
interface adder_4bit_seq_if;
   import adder_4bit_pkg::*;

   nibble_t A;
   nibble_t B;
   logic    C_in;
   nibble_t S;
   logic    C_out;
`ifdef ADDER_4BIT_OVF_EN
   logic    V;
`endif

`ifdef ADDER_4BIT_OVF_EN
   modport master (output A, output B, output C_in, input S, input C_out, input V);
   modport slave  (input A, input B, input C_in, output S, output C_out, output V);
`else
   modport master (output A, output B, output C_in, input S, input C_out);
   modport slave  (input A, input B, input C_in, output S, output C_out);
`endif

endinterface : adder_4bit_seq_if

// File: rtl/adder_4bit_seq_full_adder_1bit.sv
// Single-bit full adder cell; one stage of the adder_4bit_seq ripple chain.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule : full_adder_1bit

// File: rtl/adder_4bit_seq.sv
// Registered 4-bit ripple-carry adder: {C_out,S} = A + B + C_in, one cycle of latency.
// Define ADDER_4BIT_OVF_EN to add the registered two's-complement overflow flag V.
module adder_4bit_seq
   import adder_4bit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   adder_4bit_seq_if.slave bus
);

   logic [WIDTH:0] carry;
   nibble_t        sum_comb;
   add_res_t       res_d;
   add_res_t       res_q;

   assign carry[0] = bus.C_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder_1bit u_fa (
         .a    (bus.A[i]),
         .b    (bus.B[i]),
         .cin  (carry[i]),
         .s    (sum_comb[i]),
         .cout (carry[i+1])
      );
   end

   always_comb begin
      res_d      = '0;
      res_d.sum  = sum_comb;
      res_d.cout = carry[WIDTH];
   end

   // Output register stage
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign bus.S     = res_q.sum;
   assign bus.C_out = res_q.cout;

`ifdef ADDER_4BIT_OVF_EN
   logic v_d;
   logic v_q;

   // Overflow when carry into and out of the sign bit disagree
   assign v_d = carry[WIDTH] ^ carry[WIDTH-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= 1'b0;
      end else begin
         v_q <= v_d;
      end
   end

   assign bus.V = v_q;
`endif

endmodule : adder_4bit_seq

// File: tb/tb_adder_4bit_seq.sv
// Self-checking bench for adder_4bit_seq: directed, back-to-back, exhaustive and random vectors
// against an arithmetic reference model; V is checked when ADDER_4BIT_OVF_EN is defined.
module tb_adder_4bit_seq;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   adder_4bit_seq_if bus ();

   adder_4bit_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic; overflow from the signed interpretation of the operands
   task automatic ref_model(input int a, input int b, input int ci,
                            output int s, output int co, output int v);
      int sum;
      int sa;
      int sb;
      int ssum;
      sum  = a + b + ci;
      s    = sum % 16;
      co   = sum / 16;
      sa   = (a >= 8) ? a - 16 : a;
      sb   = (b >= 8) ? b - 16 : b;
      ssum = sa + sb + ci;
      v    = (ssum > 7 || ssum < -8) ? 1 : 0;
   endtask

   // Drive one operand set for one clock, then check the result one edge later
   task automatic step(input int a, input int b, input int ci, input bit r, input string tag);
      int es;
      int ec;
      int ev;
      bus.A    = 4'(a);
      bus.B    = 4'(b);
      bus.C_in = 1'(ci);
      rst      = r;
      @(posedge clk);
      #1;
      if (r) begin
         es = 0; ec = 0; ev = 0;
      end else begin
         ref_model(a, b, ci, es, ec, ev);
      end
      check($sformatf("%s S (%0d+%0d+%0d rst=%0d)", tag, a, b, ci, r), 32'(bus.S), 32'(es));
      check($sformatf("%s C_out (%0d+%0d+%0d rst=%0d)", tag, a, b, ci, r), 32'(bus.C_out), 32'(ec));
`ifdef ADDER_4BIT_OVF_EN
      check($sformatf("%s V (%0d+%0d+%0d rst=%0d)", tag, a, b, ci, r), 32'(bus.V), 32'(ev));
`endif
   endtask

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      bus.A    = 4'd9;
      bus.B    = 4'd9;
      bus.C_in = 1'b1;

      step(9, 9, 1, 1'b1, "reset1");
      step(9, 9, 1, 1'b1, "reset2");
      step(9, 9, 1, 1'b0, "release");
      // Absolute check of the first post-reset result
      check("release_abs S", 32'(bus.S), 32'd3);
      check("release_abs C_out", 32'(bus.C_out), 32'd1);

      step(0, 0, 0, 1'b0, "basic");
      step(3, 8, 1, 1'b0, "basic");
      step(11, 3, 0, 1'b0, "basic");
      step(12, 6, 0, 1'b0, "carry");
      step(15, 15, 0, 1'b0, "carry");
      step(15, 15, 1, 1'b0, "max");
      check("max_abs S", 32'(bus.S), 32'd15);
      check("max_abs C_out", 32'(bus.C_out), 32'd1);
      step(5, 4, 1, 1'b0, "carry");
      step(1, 9, 0, 1'b0, "carry");
      step(15, 0, 1, 1'b0, "wrap");
      check("wrap_abs S", 32'(bus.S), 32'd0);
      step(8, 8, 0, 1'b0, "ovf");
`ifdef ADDER_4BIT_OVF_EN
      check("ovf_abs V", 32'(bus.V), 32'd1);
`endif

      for (int i = 0; i < 8; i++) begin
         step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), 1'b0, "b2b");
      end

      for (int k = 0; k < 512; k++) begin
         step(k & 15, (k >> 4) & 15, (k >> 8) & 1, (k == 300), "exh");
      end

      for (int i = 0; i < 200; i++) begin
         step(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_adder_4bit_seq
